// File: rtl/hyperbolic_vectoring_cordic.sv
// Iterative hyperbolic vectoring CORDIC: (X, Y) -> theta = atanh(Y/X) and hyperbolic magnitude.
// Optional macro HVC_GAIN_COMP_EN adds a GAIN state that removes the K_h scale from Xo_final.
module hyperbolic_vectoring_cordic #(
  parameter int unsigned ITER = 16,
  parameter int unsigned W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] X_in,
  input  logic signed [W-1:0] Y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] theta_out,
  output logic signed [W-1:0] Xo_final,
  output logic                range_err
);

  localparam int unsigned XW = W + 2;
  localparam int unsigned PW = XW + 16;
  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // Shift schedule with the hyperbolic repeats at 4 and 13
  localparam logic [3:0] SCHED [ITER] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd13, 4'd14
  };

  localparam logic signed [W-1:0] ATANH [16] = '{
    16'sd0, 16'sd4500, 16'sd2092, 16'sd1029, 16'sd513, 16'sd256, 16'sd128, 16'sd64,
    16'sd32, 16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1, 16'sd1, 16'sd0
  };

`ifdef HVC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAIN = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [W-1:0]   z_q, z_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [W-1:0]   theta_q, theta_d;
  logic signed [W-1:0]   xo_q, xo_d;
  logic                  err_q, err_d;

  logic signed [XW-1:0]  x_in_ext, y_in_ext, y_in_abs, x_limit;
  logic                  range_bad;
  logic [3:0]            shift;
  logic signed [XW-1:0]  x_rot, y_rot;
  logic signed [W-1:0]   z_rot;
  logic signed [PW-1:0]  mag_wide;

  function automatic logic signed [W-1:0] sat_f(input logic signed [PW-1:0] v);
    if (v[PW-1:W-1] == {(PW-W+1){v[PW-1]}}) begin
      return v[W-1:0];
    end
    return v[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  // Convergence-domain check on the raw input vector (limit ~0.8047*X)
  always_comb begin
    x_in_ext  = {{(XW-W){X_in[W-1]}}, X_in};
    y_in_ext  = {{(XW-W){Y_in[W-1]}}, Y_in};
    y_in_abs  = y_in_ext[XW-1] ? -y_in_ext : y_in_ext;
    x_limit   = x_in_ext - (x_in_ext >>> 3) - (x_in_ext >>> 4) - (x_in_ext >>> 7);
    range_bad = x_in_ext[XW-1] || (x_in_ext == '0) || (y_in_abs > x_limit);
  end

  // One micro-rotation from the current registers; both updates use old x/y
  always_comb begin
    shift = SCHED[cnt_q];
    if (!y_q[XW-1]) begin
      x_rot = x_q - (y_q >>> shift);
      y_rot = y_q - (x_q >>> shift);
      z_rot = z_q + ATANH[shift];
    end else begin
      x_rot = x_q + (y_q >>> shift);
      y_rot = y_q + (x_q >>> shift);
      z_rot = z_q - ATANH[shift];
    end
  end

`ifdef HVC_GAIN_COMP_EN
  localparam logic signed [PW-1:0] GAIN_K   = PW'(9892);
  localparam logic signed [PW-1:0] HALF_LSB = PW'(4096);
  logic signed [PW-1:0] x_q_wide, gain_prod;

  // 1/K_h scaling in Q2.13 with half-up rounding
  always_comb begin
    x_q_wide  = {{(PW-XW){x_q[XW-1]}}, x_q};
    gain_prod = x_q_wide * GAIN_K;
    mag_wide  = (gain_prod + HALF_LSB) >>> 13;
  end
`else
  always_comb begin
    mag_wide = {{(PW-XW){x_rot[XW-1]}}, x_rot};
  end
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    theta_d  = theta_q;
    xo_d     = xo_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (range_bad) begin
            state_d = DONE;
            theta_d = '0;
            xo_d    = '0;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            x_d     = x_in_ext;
            y_d     = y_in_ext;
            z_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef HVC_GAIN_COMP_EN
          state_d = GAIN;
`else
          state_d = DONE;
          theta_d = z_rot;
          xo_d    = sat_f(mag_wide);
          err_d   = 1'b0;
`endif
        end
      end
`ifdef HVC_GAIN_COMP_EN
      GAIN: begin
        state_d = DONE;
        theta_d = z_q;
        xo_d    = sat_f(mag_wide);
        err_d   = 1'b0;
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      theta_q     <= '0;
      xo_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      theta_q     <= theta_d;
      xo_q        <= xo_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign theta_out = theta_q;
  assign Xo_final  = xo_q;
  assign range_err = err_q;

endmodule

// File: doc/hyperbolic_vectoring_cordic.md
# hyperbolic_vectoring_cordic

Iterative hyperbolic CORDIC in vectoring mode: the inverse of the pipelined rotation-mode cosh/sinh engine. It accepts a vector (X, Y) and drives Y to zero over 16 micro-rotations, returning theta = atanh(Y/X) and the hyperbolic magnitude sqrt(X²−Y²). It sits downstream of the rotation pipeline, recovering angles for closed-loop checks and log/atanh evaluation. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- ITER, 16: micro-rotation count including repeats; fixed schedule below, not to be changed.
- W, 16: data width of X, Y and theta.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept; high only in IDLE.
- X_in  in  16  signed Q3.12.
- Y_in  in  16  signed Q3.12.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- theta_out  out  16  signed Q2.13, atanh(Y/X).
- Xo_final  out  16  signed Q3.12 magnitude, saturated.
- range_err  out  1  input outside convergence domain; qualified by out_valid.

## Operation
- FSM states: IDLE, RUN, GAIN (only with the macro), DONE.
- IDLE → RUN on in_valid && in_ready.
  - Load x, y sign-extended to 18 bits. Load z = 0 and cnt = 0.
- Range check at accept: range_err = (X_in ≤ 0) or (|Y_in| > X_in − (X_in>>>3) − (X_in>>>4) − (X_in>>>7)).
  - The right-hand limit is ≈0.8047·X.
  - On error: go IDLE → DONE directly. theta_out = 0, Xo_final = 0, range_err = 1.
- RUN performs one micro-rotation per cycle with shift s = SCHED[cnt].
  - SCHED = 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14.
  - If y ≥ 0: x ← x − (y>>>s); y ← y − (x>>>s); z ← z + ATANH[s].
  - Else: x ← x + (y>>>s); y ← y + (x>>>s); z ← z − ATANH[s].
  - Both updates use the old x and y. Shifts are arithmetic and truncating.
- ATANH ROM values (Q2.13) for s = 1..14: 4500, 2092, 1029, 513, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1.
- After cnt = 15: go to GAIN if the macro is defined, else to DONE.
- Output registers load on entering DONE:
  - theta_out = z.
  - Xo_final = x, saturated to [0x8000, 0x7FFF].
  - range_err = 0.
- DONE → IDLE on out_ready. Output registers then hold their values, but out_valid drops.
- Reset asserted at any time, including mid-RUN:
  - Immediately: state IDLE; all outputs 0; in_ready 0.
  - in_ready goes to 1 on the first clk edge after reset deasserts.
  - Any in-flight operation is discarded.

## Timing
- Accept edge E0. Micro-rotations occur at edges E1..E16.
- out_valid rises after E16 without the macro, or after E17 with it.
- Range-error path: out_valid rises after E0, giving 1-cycle latency.
- in_ready is low from E0 until the cycle after the output handshake. There is no overlap; minimum period is 18 cycles (19 with the macro).
- out_valid, theta_out, Xo_final and range_err are stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. The simultaneous out handshake and new in_valid in DONE are not accepted in the same cycle.

## Configuration
- HVC_GAIN_COMP_EN:
  - Defined: the GAIN state multiplies x by 9892 (1/K_h = 1.20750 in Q2.13). Rounding is half-up, then >>>13, then saturate; Xo_final = sqrt(X²−Y²).
  - Undefined: no GAIN state; Xo_final = K_h·sqrt(X²−Y²) with K_h ≈ 0.82816.
- theta_out is identical in both builds.

## Test plan
- X=0x1000, Y=0x0800 → theta_out=0x1194 ±4. Xo_final=0x0B7A ±4 (uncompensated) or 0x0DDB ±4 (compensated). range_err=0. out_valid after exactly 16 (17) cycles.
- X=0x1000, Y=0xF800 → theta_out=0xEE6C ±4; Xo_final as above.
- X=0x1000, Y=0x0E00 → range_err=1, theta_out=0, Xo_final=0, out_valid one cycle after accept. Also X=0x0000 → range_err=1.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0. Then pulse out_ready → out_valid=0 and in_ready=1 next cycle.
- Assert reset at cycle 8 of RUN → out_valid, in_ready, theta_out and Xo_final all 0 immediately. A fresh X=0x1000, Y=0 after release → theta_out=0x0000 ±4.
- Back-to-back random in-range vectors with random out_ready stalls → every result matches the reference model within ±4 LSB; no lost or duplicated transactions.
